// File: rtl/multicycle_alu.sv
// Multicycle ALU with single-cycle logic/shift ops plus iterative shift-add multiply and restoring divide.
// Define ALU_MULDIV_EN to build the multiply/divide datapath; otherwise opcodes 11-15 pass A in one cycle.
module multicycle_alu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iStart,
    input  logic [3:0]       iControl,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    output logic             oBusy,
    output logic             oDone,
    output logic [WIDTH-1:0] oResult,
    output logic             oZero
);
    localparam int SH_W = $clog2(WIDTH);

`ifdef ALU_MULDIV_EN
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_DONE} state_t;
`endif

    state_t           state_reg, state_next;
    logic             accept;
    logic [SH_W-1:0]  shamt;
    logic [WIDTH-1:0] single_result;
    logic [WIDTH-1:0] result_reg;

    assign accept  = iStart && !oBusy;
    assign shamt   = iB[SH_W-1:0];
    assign oResult = result_reg;
    assign oZero   = (result_reg == '0);

    always_comb begin
        single_result = iA;
        case (iControl)
            4'd0:    single_result = iA & iB;
            4'd1:    single_result = iA | iB;
            4'd2:    single_result = iA + iB;
            4'd3:    single_result = iA - iB;
            4'd4:    single_result = {{(WIDTH-1){1'b0}}, ($signed(iA) < $signed(iB))};
            4'd5:    single_result = iB;
            4'd6:    single_result = iA ^ iB;
            4'd7:    single_result = {{(WIDTH-1){1'b0}}, (iA < iB)};
            4'd8:    single_result = iA << shamt;
            4'd9:    single_result = iA >> shamt;
            4'd10:   single_result = $unsigned($signed(iA) >>> shamt);
            default: single_result = iA;
        endcase
    end

`ifdef ALU_MULDIV_EN
    logic [CNT_W-1:0] cnt_reg;
    logic             last_iter;
    logic [WIDTH-1:0] a_reg, mcand_reg, mplier_reg, acc_reg;
    logic [WIDTH-1:0] divisor_reg, quot_reg, rem_reg;
    logic             a_neg_reg, b_neg_reg, div_zero_reg, is_rem_reg;
    logic             start_signed, start_a_neg, start_b_neg;
    logic [WIDTH-1:0] acc_next, quot_next, rem_next, div_result;
    logic [WIDTH:0]   div_shift, div_trial;

    assign start_signed = (iControl == 4'd12) || (iControl == 4'd14);
    assign start_a_neg  = start_signed && iA[WIDTH-1];
    assign start_b_neg  = start_signed && iB[WIDTH-1];
    assign last_iter    = (cnt_reg == CNT_W'(WIDTH-1));

    always_comb begin
        acc_next  = mplier_reg[0] ? acc_reg + mcand_reg : acc_reg;
        div_shift = {rem_reg, quot_reg[WIDTH-1]};
        div_trial = div_shift - {1'b0, divisor_reg};
        // Non-negative trial difference means the divisor fits: keep it and emit a 1.
        if (!div_trial[WIDTH]) begin
            quot_next = {quot_reg[WIDTH-2:0], 1'b1};
            rem_next  = div_trial[WIDTH-1:0];
        end else begin
            quot_next = {quot_reg[WIDTH-2:0], 1'b0};
            rem_next  = div_shift[WIDTH-1:0];
        end
        if (div_zero_reg)
            div_result = is_rem_reg ? a_reg : '1;
        else if (is_rem_reg)
            div_result = a_neg_reg ? -rem_next : rem_next;
        else
            div_result = (a_neg_reg ^ b_neg_reg) ? -quot_next : quot_next;
    end
`endif

    always_ff @(posedge iCLK) begin
        if (iRST)
            state_reg <= S_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE, S_DONE: begin
                state_next = S_IDLE;
                if (accept) begin
                    state_next = S_DONE;
`ifdef ALU_MULDIV_EN
                    if (iControl == 4'd11)
                        state_next = S_MUL;
                    else if (iControl > 4'd11)
                        state_next = S_DIV;
`endif
                end
            end
`ifdef ALU_MULDIV_EN
            S_MUL, S_DIV: begin
                if (last_iter)
                    state_next = S_DONE;
            end
`endif
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        oBusy = 1'b0;
        oDone = 1'b0;
        case (state_reg)
            S_DONE: oDone = 1'b1;
`ifdef ALU_MULDIV_EN
            S_MUL, S_DIV: oBusy = 1'b1;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            result_reg <= '0;
`ifdef ALU_MULDIV_EN
            cnt_reg      <= '0;
            a_reg        <= '0;
            mcand_reg    <= '0;
            mplier_reg   <= '0;
            acc_reg      <= '0;
            divisor_reg  <= '0;
            quot_reg     <= '0;
            rem_reg      <= '0;
            a_neg_reg    <= 1'b0;
            b_neg_reg    <= 1'b0;
            div_zero_reg <= 1'b0;
            is_rem_reg   <= 1'b0;
`endif
        end else begin
            if (accept) begin
`ifdef ALU_MULDIV_EN
                if (iControl < 4'd11)
                    result_reg <= single_result;
                cnt_reg      <= '0;
                a_reg        <= iA;
                mcand_reg    <= iA;
                mplier_reg   <= iB;
                acc_reg      <= '0;
                rem_reg      <= '0;
                quot_reg     <= start_a_neg ? -iA : iA;
                divisor_reg  <= start_b_neg ? -iB : iB;
                a_neg_reg    <= start_a_neg;
                b_neg_reg    <= start_b_neg;
                div_zero_reg <= (iB == '0);
                is_rem_reg   <= iControl[1];
`else
                result_reg <= single_result;
`endif
            end
`ifdef ALU_MULDIV_EN
            if (state_reg == S_MUL) begin
                acc_reg    <= acc_next;
                mcand_reg  <= mcand_reg << 1;
                mplier_reg <= mplier_reg >> 1;
                cnt_reg    <= cnt_reg + CNT_W'(1);
                if (last_iter)
                    result_reg <= acc_next;
            end
            if (state_reg == S_DIV) begin
                quot_reg <= quot_next;
                rem_reg  <= rem_next;
                cnt_reg  <= cnt_reg + CNT_W'(1);
                if (last_iter)
                    result_reg <= div_result;
            end
`endif
        end
    end
endmodule

// File: tb/tb_multicycle_alu.sv
// Randomized self-checking bench for multicycle_alu against an arithmetic reference model.
// Expectations for opcodes 11-15 follow whether ALU_MULDIV_EN is defined for this build.
module tb_multicycle_alu;
    localparam int W = 32;

    logic         iCLK = 1'b0;
    logic         iRST;
    logic         iStart;
    logic [3:0]   iControl;
    logic [W-1:0] iA, iB;
    logic         oBusy, oDone, oZero;
    logic [W-1:0] oResult;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 iCLK = ~iCLK;

    multicycle_alu #(.WIDTH(W), .CNT_W(6)) dut (
        .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iControl(iControl),
        .iA(iA), .iB(iB), .oBusy(oBusy), .oDone(oDone), .oResult(oResult), .oZero(oZero)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        int     sh;
        sa = $signed(a);
        sb = $signed(b);
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sh = int'(b[4:0]);
        case (op)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return 32'(ua + ub);
            4'd3:  return 32'(ua - ub);
            4'd4:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd5:  return b;
            4'd6:  return a ^ b;
            4'd7:  return (ua < ub) ? 32'd1 : 32'd0;
            4'd8:  return 32'(ua << sh);
            4'd9:  return 32'(ua >> sh);
            4'd10: return 32'(sa >>> sh);
`ifdef ALU_MULDIV_EN
            4'd11: return 32'(sa * sb);
            4'd12: return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
            4'd13: return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
            4'd14: return (b == 0) ? a : 32'(sa % sb);
            4'd15: return (b == 0) ? a : 32'(ua % ub);
`endif
            default: return a;
        endcase
    endfunction

    function automatic int latency(input logic [3:0] op);
`ifdef ALU_MULDIV_EN
        return (op >= 4'd11) ? W + 1 : 1;
`else
        return (op >= 4'd11) ? 1 : 1;
`endif
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 40));
            5:       return -32'($urandom_range(1, 40));
            default: return $urandom;
        endcase
    endfunction

    // Called at #1 after a rising edge; returns in the DONE cycle (back_to_back) or one cycle later.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit mid_pulse, input bit back_to_back);
        logic [31:0] exp;
        int          n, busy_n, lat;
        exp = model(op, a, b);
        lat = latency(op);
        iStart = 1'b1; iControl = op; iA = a; iB = b;
        @(posedge iCLK); #1;
        iStart = 1'b0; iControl = 4'($urandom); iA = $urandom; iB = $urandom;
        n = 1;
        busy_n = 0;
        while (!oDone && n <= W + 10) begin
            if (oBusy) busy_n++;
            if (mid_pulse && n == 5) begin
                iStart = 1'b1; iControl = 4'($urandom); iA = $urandom; iB = $urandom;
            end else begin
                iStart = 1'b0;
            end
            @(posedge iCLK); #1;
            n++;
        end
        iStart = 1'b0;
        check_eq({tag, " done"}, 64'(oDone), 64'd1);
        check_eq({tag, " latency"}, 64'(n), 64'(lat));
        check_eq({tag, " busy_cycles"}, 64'(busy_n), 64'(lat - 1));
        check_eq({tag, " busy_in_done"}, 64'(oBusy), 64'd0);
        check_eq({tag, " result"}, 64'(oResult), 64'(exp));
        check_eq({tag, " zero"}, 64'(oZero), 64'(exp == 0));
        $display("[TB] %s op=%0d a=%h b=%h result=%h expected=%h cycles=%0d", tag, op, a, b, oResult, exp, n);
        if (!back_to_back) begin
            @(posedge iCLK); #1;
            check_eq({tag, " done_pulse"}, 64'(oDone), 64'd0);
            check_eq({tag, " held"}, 64'(oResult), 64'(exp));
        end
    endtask

    initial begin
        iRST = 1'b1; iStart = 1'b0; iControl = 4'd0; iA = '0; iB = '0;
        repeat (2) @(posedge iCLK);
        #1;
        check_eq("reset busy", 64'(oBusy), 64'd0);
        check_eq("reset done", 64'(oDone), 64'd0);
        check_eq("reset result", 64'(oResult), 64'd0);
        check_eq("reset zero", 64'(oZero), 64'd1);
        iRST = 1'b0;

        run_op("add_wrap", 4'd2, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        run_op("slt", 4'd4, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        run_op("sltu", 4'd7, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);
        run_op("sra", 4'd10, 32'h8000_00F0, 32'hFFFF_FFE4, 1'b0, 1'b0);
        run_op("mul", 4'd11, -32'd3, 32'd7, 1'b1, 1'b0);
        run_op("div", 4'd12, -32'd7, 32'd2, 1'b0, 1'b1);
        run_op("rem", 4'd14, -32'd7, 32'd2, 1'b0, 1'b0);
        run_op("divu_zero", 4'd13, 32'd7, 32'd0, 1'b0, 1'b0);
        run_op("remu_zero", 4'd15, 32'd7, 32'd0, 1'b0, 1'b0);
        run_op("div_ovf", 4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("rem_ovf", 4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);

        // Abort a divide partway through with reset, then issue immediately after release.
        iStart = 1'b1; iControl = 4'd12; iA = 32'd100; iB = 32'd7;
        @(posedge iCLK); #1;
        iStart = 1'b0;
        repeat (9) begin
            @(posedge iCLK); #1;
        end
        iRST = 1'b1;
        @(posedge iCLK); #1;
        check_eq("abort done", 64'(oDone), 64'd0);
        check_eq("abort result", 64'(oResult), 64'd0);
        check_eq("abort busy", 64'(oBusy), 64'd0);
        iRST = 1'b0;
        run_op("post_reset_add", 4'd2, 32'd2, 32'd3, 1'b0, 1'b0);

        for (int i = 0; i < 200; i++) begin
            run_op($sformatf("rand%0d", i), 4'($urandom_range(0, 15)), pick_operand(), pick_operand(),
                   $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
        end
        @(posedge iCLK); #1;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width in bits (legal values 8..64).
REQ-002 SHALL have parameter CNT_W, default 6, meaning iteration counter width; CNT_W SHALL be at least clog2(WIDTH)+1.
REQ-003 iCLK  input  1  sole clock; all state changes on the rising edge.
REQ-004 iRST  input  1  reset, synchronous, active-high.
REQ-005 iStart  input  1  operation request, sampled on the rising edge of iCLK.
REQ-006 iControl  input  4  opcode: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLT, 5 FWD (pass B), 6 XOR, 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 MUL, 12 DIV, 13 DIVU, 14 REM, 15 REMU.
REQ-007 iA  input  WIDTH  operand A, signed or unsigned per opcode.
REQ-008 iB  input  WIDTH  operand B, signed or unsigned per opcode.
REQ-009 oBusy  output  1  high while an operation is in progress; iStart is ignored while oBusy is high.
REQ-010 oDone  output  1  one-cycle pulse indicating oResult is valid.
REQ-011 oResult  output  WIDTH  registered result, held until the next oDone.
REQ-012 oZero  output  1  combinational, asserted when oResult is all zeros.

Function
REQ-013 SHALL implement FSM states IDLE, MUL, DIV and DONE.
REQ-014 SHALL latch iControl, iA and iB only on an accept, defined as iStart high and oBusy low in the same cycle.
REQ-015 Single-cycle opcodes (0-10) SHALL transition IDLE to DONE on accept, so oDone is high exactly 1 cycle after the accept edge.
REQ-016 SLT SHALL compare signed and SLTU unsigned, producing 1 or 0 zero-extended to WIDTH.
REQ-017 Shift opcodes (SLL, SRL, SRA) SHALL use only the low clog2(WIDTH) bits of iB as the shift amount; SRA sign-extends.
REQ-018 ADD and SUB SHALL wrap modulo 2^WIDTH, with no overflow flag.
REQ-019 MUL SHALL run a shift-add loop: IDLE to MUL for exactly WIDTH iterations, then DONE.
REQ-020 MUL SHALL return the low WIDTH bits of the product; oDone is high WIDTH+1 cycles after accept.
REQ-021 DIV, DIVU, REM and REMU SHALL run restoring division: IDLE to DIV for exactly WIDTH iterations, then DONE, giving the same WIDTH+1 latency.
REQ-022 Signed division SHALL operate on magnitudes and then correct signs: the quotient sign is sign(A) XOR sign(B), and the remainder takes the sign of A.
REQ-023 Division by zero SHALL return all-ones for DIV and DIVU, and A for REM and REMU, with the same WIDTH+1 latency.
REQ-024 Signed overflow (A = most-negative, B = -1) SHALL return most-negative for DIV and 0 for REM.
REQ-025 oBusy SHALL go high on the edge after accept and stay high through MUL/DIV; in DONE it is low.
REQ-026 DONE SHALL last one cycle and return to IDLE; iStart in the DONE cycle SHALL be accepted, allowing back-to-back issue.
REQ-027 iStart while oBusy is high SHALL be ignored, with no queuing and no effect on the in-flight operation.
REQ-028 Operand changes on iA, iB or iControl after accept SHALL NOT affect the in-flight result.
REQ-029 oResult SHALL update only on the edge that sets oDone.

Reset
REQ-030 While iRST is high at a rising edge, the FSM SHALL enter IDLE, oBusy=0, oDone=0, oResult=0, and the iteration counter and partial registers are cleared.
REQ-031 iRST SHALL take priority over iStart; reset during MUL or DIV SHALL abort the operation with no oDone pulse.
REQ-032 The first accept SHALL be possible in the cycle after iRST deasserts.

Configuration
REQ-033 Macro ALU_MULDIV_EN SHALL gate the multiply/divide datapath.
REQ-034 With ALU_MULDIV_EN defined, opcodes 11-15 SHALL behave per REQ-019 to REQ-024.
REQ-035 Without ALU_MULDIV_EN, the MUL and DIV states and their datapath SHALL be absent.
REQ-036 Without ALU_MULDIV_EN, opcodes 11-15 SHALL complete in 1 cycle with oResult = iA (legacy pass-A default).

Verification (WIDTH=32, ALU_MULDIV_EN defined unless noted)
REQ-037 ADD A=0xFFFFFFFF, B=1 -> oDone 1 cycle after accept, oResult=0, oZero=1; SLT A=-1, B=1 -> 1; SLTU with the same operands -> 0.
REQ-038 MUL A=-3, B=7 -> oBusy high 32 cycles, oDone at accept+33, oResult=0xFFFFFFEB; iStart pulsed mid-operation has no effect.
REQ-039 DIV A=-7, B=2 -> quotient 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF; DIVU 7/0 -> 0xFFFFFFFF; REMU 7/0 -> 7.
REQ-040 DIV A=0x80000000, B=-1 -> 0x80000000; REM with the same operands -> 0.
REQ-041 iRST asserted 10 cycles into DIV -> no oDone, oResult=0, oBusy=0 next cycle; ADD 2+3 accepted the cycle after reset release -> 5.
REQ-042 ALU_MULDIV_EN undefined: MUL A=6, B=7 -> oDone 1 cycle after accept, oResult=6.
